uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the processor data bus.
- It is the serial, outbound counterpart of the parallel input port.
- A store to the TX data address pushes one byte into a small FIFO. A serializer shifts the byte out on UART_TXD as 8N1, LSB first.
- A status word is readable through a load mux that sits in the write-back path, in the same way as the parallel input mux.

---
 rtl/uart_tx_mmio.sv | 159 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO, 8N1 serializer, status word on the load mux.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1); status bit 4 then reads 1.
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] TX_DATA_ADDR = 32'h0000_00F8,
  parameter logic [31:0] TX_STAT_ADDR = 32'h0000_00F4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Address,
  input  logic [7:0]  RegData,
  input  logic [31:0] MemData,
  output logic [31:0] RegData_out,
  output logic        UART_TXD,
  output logic        busy
);

  localparam int unsigned Div  = CLK_FREQ / BAUD;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned Aw   = $clog2(DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic ParEn = 1'b1;
`else
  localparam logic ParEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem_q [DEPTH];
  logic [Aw-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Aw:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            empty, full, bit_end, pop, push_req, push_ok, clr_req;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == (Aw+1)'(DEPTH));
  assign bit_end  = (baud_q == CntW'(Div - 1));
  assign push_req = EN && (Address == TX_DATA_ADDR);
  assign clr_req  = EN && (Address == TX_STAT_ADDR) && RegData[0];
  // A full FIFO still accepts a push when the serializer pops on the same edge.
  assign push_ok  = push_req && (!full || pop);

  assign busy        = (state_q != StIdle) || !empty;
  assign RegData_out = (Address == TX_STAT_ADDR) ?
                       {27'b0, ParEn, ovf_q, empty, full, busy} : MemData;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    UART_TXD = 1'b1;
    baud_d   = (state_q == StIdle || bit_end) ? '0 : baud_q + CntW'(1);
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        UART_TXD = 1'b0;
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        UART_TXD = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ParEn ? StParity : StStop;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        UART_TXD = par_q;
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rptr_q];
`endif
    end
  end

  always_comb begin
    wptr_d  = push_ok ? wptr_q + Aw'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + Aw'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop) count_d = count_q + (Aw+1)'(1);
    if (!push_ok && pop) count_d = count_q - (Aw+1)'(1);
    ovf_d = ovf_q;
    if (clr_req) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) mem_q[wptr_q] <= RegData;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a line monitor decodes frames, tasks compare them
// against frames and FIFO occupancy derived from the transmitter's documented rules.
module tb_uart_tx_mmio;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned DEPTH    = 4;
  localparam int DIV = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [31:0] PAR_BIT = 32'h10;
`else
  localparam int FB = 10;
  localparam logic [31:0] PAR_BIT = 32'h0;
`endif
  localparam int FRAME = FB * DIV;
  localparam logic [31:0] DATA_A = 32'h0000_00F8;
  localparam logic [31:0] STAT_A = 32'h0000_00F4;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [31:0] Address;
  logic [7:0]  RegData;
  logic [31:0] MemData;
  logic [31:0] RegData_out;
  logic        UART_TXD;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [10:0] mon_bits[$];
  int          mon_fall[$];

  uart_tx_mmio #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .DEPTH       (DEPTH),
    .TX_DATA_ADDR(DATA_A),
    .TX_STAT_ADDR(STAT_A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .EN         (EN),
    .Address    (Address),
    .RegData    (RegData),
    .MemData    (MemData),
    .RegData_out(RegData_out),
    .UART_TXD   (UART_TXD),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    EN      = 1'b1;
    Address = a;
    RegData = d;
    tick();
    EN      = 1'b0;
    Address = 32'h0;
  endtask

  // Frame as seen on the line, bit 0 = start bit.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    f[8:1] = b;
    if (FB == 11) f[9] = ^b;
    f[FB-1] = 1'b1;
    return f;
  endfunction

  // Line monitor: on a low level, sample every bit in its middle.
  initial begin
    logic [10:0] bits;
    int fall;
    forever begin
      tick();
      if (UART_TXD === 1'b0) begin
        fall = cyc;
        bits = '0;
        for (int k = 0; k < FB; k++) begin
          repeat ((k == 0) ? DIV / 2 : DIV) @(posedge clk);
          #1;
          bits[k] = UART_TXD;
        end
        mon_bits.push_back(bits);
        mon_fall.push_back(fall);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    Address = STAT_A;
    #1;
    total++;
    if (RegData_out !== (32'h4 | PAR_BIT)) begin
      bad++;
      $display("FAIL reset_stat_in_reset got=%h want=%h", RegData_out, 32'h4 | PAR_BIT);
    end
    rst = 1'b1;
    tick();
    total++;
    if (UART_TXD !== 1'b1) begin
      bad++;
      $display("FAIL reset_txd got=%b want=1", UART_TXD);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if (RegData_out !== (32'h4 | PAR_BIT)) begin
      bad++;
      $display("FAIL reset_stat got=%h want=%h", RegData_out, 32'h4 | PAR_BIT);
    end
    Address = 32'h0;
  endtask

  task automatic test_single(input logic [7:0] b);
    int n;
    mon_bits.delete();
    mon_fall.delete();
    store(DATA_A, b);
    n = cyc;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_on byte=%h got=%b want=1", b, busy);
    end
    wait_until(n + FRAME);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_hold byte=%h got=%b want=1", b, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || UART_TXD !== 1'b1) begin
      bad++;
      $display("FAIL single_idle byte=%h busy=%b txd=%b want busy=0 txd=1", b, busy, UART_TXD);
    end
    total++;
    if (mon_bits.size() != 1) begin
      bad++;
      $display("FAIL single_count byte=%h got=%0d want=1", b, mon_bits.size());
    end
    if (mon_bits.size() >= 1) begin
      total++;
      if (mon_fall[0] != n + 1) begin
        bad++;
        $display("FAIL single_latency byte=%h got=%0d want=%0d", b, mon_fall[0], n + 1);
      end
      total++;
      if (mon_bits[0] !== exp_frame(b)) begin
        bad++;
        $display("FAIL single_frame byte=%h got=%b want=%b", b, mon_bits[0], exp_frame(b));
      end
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2);
    logic [7:0] exp_b[3];
    int n;
    exp_b[0] = b0;
    exp_b[1] = b1;
    exp_b[2] = b2;
    mon_bits.delete();
    mon_fall.delete();
    store(DATA_A, b0);
    n = cyc;
    store(DATA_A, b1);
    store(DATA_A, b2);
    wait_until(n + 3 * FRAME);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy_hold got=%b want=1", busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy_end got=%b want=0", busy);
    end
    total++;
    if (mon_bits.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=3", mon_bits.size());
    end
    for (int i = 0; i < 3 && i < mon_bits.size(); i++) begin
      total++;
      if (mon_fall[i] != n + 1 + i * FRAME || mon_bits[i] !== exp_frame(exp_b[i])) begin
        bad++;
        $display("FAIL b2b_frame%0d got fall=%0d bits=%b want fall=%0d bits=%b", i,
                 mon_fall[i], mon_bits[i], n + 1 + i * FRAME, exp_frame(exp_b[i]));
      end
    end
  endtask

  task automatic test_overflow(input bit fixed);
    logic [7:0] d[6];
    logic [7:0] acc[$];
    logic [31:0] exp_stat;
    int cnt = 0;
    int dropped = 0;
    int n;
    for (int i = 0; i < 6; i++) d[i] = fixed ? 8'(8'h10 + i) : 8'($urandom());
    // Occupancy model: only the first byte leaves the FIFO within these six edges.
    for (int i = 0; i < 6; i++) begin
      if (i == 1) cnt--;
      if (cnt < int'(DEPTH)) begin
        acc.push_back(d[i]);
        cnt++;
      end else begin
        dropped++;
      end
    end
    exp_stat = PAR_BIT | {28'b0, dropped > 0, cnt == 0, cnt == int'(DEPTH), 1'b1};
    mon_bits.delete();
    mon_fall.delete();
    store(DATA_A, d[0]);
    n = cyc;
    for (int i = 1; i < 6; i++) store(DATA_A, d[i]);
    Address = STAT_A;
    #1;
    total++;
    if (RegData_out !== exp_stat) begin
      bad++;
      $display("FAIL ovf_stat got=%h want=%h", RegData_out, exp_stat);
    end
    store(STAT_A, 8'hFE);
    Address = STAT_A;
    #1;
    total++;
    if (RegData_out !== exp_stat) begin
      bad++;
      $display("FAIL ovf_noclear got=%h want=%h", RegData_out, exp_stat);
    end
    store(STAT_A, 8'($urandom()) | 8'h01);
    Address = STAT_A;
    #1;
    total++;
    if (RegData_out !== (exp_stat & ~32'h8)) begin
      bad++;
      $display("FAIL ovf_clear got=%h want=%h", RegData_out, exp_stat & ~32'h8);
    end
    Address = 32'h0;
    wait_until(n + 1 + acc.size() * FRAME);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ovf_busy_end got=%b want=0", busy);
    end
    total++;
    if (mon_bits.size() != acc.size()) begin
      bad++;
      $display("FAIL ovf_count got=%0d want=%0d", mon_bits.size(), acc.size());
    end
    for (int i = 0; i < acc.size() && i < mon_bits.size(); i++) begin
      total++;
      if (mon_fall[i] != n + 1 + i * FRAME || mon_bits[i] !== exp_frame(acc[i])) begin
        bad++;
        $display("FAIL ovf_frame%0d got fall=%0d bits=%b want fall=%0d bits=%b", i,
                 mon_fall[i], mon_bits[i], n + 1 + i * FRAME, exp_frame(acc[i]));
      end
    end
  endtask

  task automatic test_reset_mid_frame(input int off);
    int n;
    int lows = 0;
    store(DATA_A, 8'hFF);
    n = cyc;
    // Data bit 3 occupies frame slot 4, i.e. edges F+4*DIV .. F+5*DIV-1 with F = n+1.
    wait_until(n + 1 + 4 * DIV + off - 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (UART_TXD !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_line txd=%b busy=%b want txd=1 busy=0", UART_TXD, busy);
    end
    Address = STAT_A;
    #1;
    total++;
    if (RegData_out !== (32'h4 | PAR_BIT)) begin
      bad++;
      $display("FAIL midrst_stat got=%h want=%h", RegData_out, 32'h4 | PAR_BIT);
    end
    Address = 32'h0;
    repeat (2 * FRAME) begin
      tick();
      if (UART_TXD !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL midrst_quiet got=%0d low cycles want=0", lows);
    end
    test_single(8'h55);
  endtask

  task automatic test_passthrough();
    logic [31:0] a;
    logic [31:0] md;
    EN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a  = (i == 0) ? 32'h10 : (i == 1) ? DATA_A : $urandom();
      if (a == STAT_A) a = a ^ 32'h1;
      md = (i == 0) ? 32'hDEAD_BEEF : $urandom();
      Address = a;
      MemData = md;
      #1;
      total++;
      if (RegData_out !== md) begin
        bad++;
        $display("FAIL passthru addr=%h got=%h want=%h", a, RegData_out, md);
      end
    end
    Address = 32'h0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b0;
    EN      = 1'b0;
    Address = 32'h0;
    RegData = 8'h0;
    MemData = 32'h0;
    test_reset();
    test_single(8'hA5);
    test_single(8'h07);
    repeat (3) test_single(8'($urandom()));
    test_back_to_back(8'h01, 8'h02, 8'h03);
    test_back_to_back(8'($urandom()), 8'($urandom()), 8'($urandom()));
    test_overflow(1'b1);
    test_overflow(1'b0);
    test_reset_mid_frame(3);
    test_reset_mid_frame(int'($urandom_range(DIV - 1, 1)));
    test_passthrough();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
